// File: rtl/signed_value_counter_pkg.sv
// Shared types and constants for signed_value_counter: repeat-FSM state,
// value range limits and a small constant helper for counter sizing.
package signed_value_counter_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_t;

  localparam logic signed [7:0] VALUE_MAX = 8'sh7F;  // +127
  localparam logic signed [7:0] VALUE_MIN = 8'sh80;  // -128

  // Larger of two unsigned values, used to size shared counters.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/signed_value_counter_if.sv
// Button inputs and value/changed outputs of signed_value_counter.
// The master side drives the buttons; the slave side is the counter.
interface signed_value_counter_if;

  logic       btn_up;
  logic       btn_down;
  logic       btn_clear;
  logic [7:0] value;
  logic       changed;

  modport master (
    output btn_up, btn_down, btn_clear,
    input  value, changed
  );

  modport slave (
    input  btn_up, btn_down, btn_clear,
    output value, changed
  );

endinterface

// File: rtl/signed_value_counter_button_debouncer.sv
// button_debouncer: 2-flop synchroniser followed by a stability counter.
// The debounced level follows the synchronised input only after
// DEBOUNCE_CYCLES consecutive samples at the new level; any sample back
// at the current level restarts the count.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic btn,
  output logic level
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;

  // Two-stage synchroniser for the raw asynchronous button.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) sync_q <= 2'b00;
    else       sync_q <= {sync_q[0], btn};
  end

  // Count consecutive samples differing from the accepted level.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      level <= 1'b0;
    end else if (sync_q[1] == level) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      cnt_q <= '0;
      level <= sync_q[1];
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/signed_value_counter_repeat.sv
// Auto-repeat FSM for one button direction (IDLE -> DELAY -> REPEAT).
// Compiled only when SIGNED_VALUE_COUNTER_AUTO_REPEAT_EN is defined.
`ifdef SIGNED_VALUE_COUNTER_AUTO_REPEAT_EN
module signed_value_counter_repeat
  import signed_value_counter_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 50000000,
  parameter int unsigned REPEAT_PERIOD = 10000000
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic held,     // debounced level of this direction
  input  logic rise,     // debounced rising edge of this direction
  input  logic inhibit,  // both directions held: no stepping
  output logic step_c
);

  localparam int unsigned CNT_W = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  rpt_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and hold-time counter registers.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_q <= RPT_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter and step strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_c  = 1'b0;
    if (!held || inhibit) begin
      state_d = RPT_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RPT_IDLE: begin
          if (rise) begin
            step_c  = 1'b1;
            state_d = RPT_DELAY;
            cnt_d   = '0;
          end
        end
        RPT_DELAY: begin
          if (cnt_q == CNT_W'(REPEAT_DELAY - 1)) begin
            step_c  = 1'b1;
            state_d = RPT_REPEAT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RPT_REPEAT: begin
          if (cnt_q == CNT_W'(REPEAT_PERIOD - 1)) begin
            step_c = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = RPT_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule
`endif

// File: rtl/signed_value_counter.sv
// signed_value_counter: 8-bit two's-complement up/down/clear counter driven
// by three debounced push buttons, with optional hold-to-repeat stepping.
// Build option: define SIGNED_VALUE_COUNTER_AUTO_REPEAT_EN to include the
// auto-repeat FSMs; without it every press yields exactly one step.
module signed_value_counter
  import signed_value_counter_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000,
  parameter int unsigned WRAP            = 0
) (
  input  logic                  clk_100MHz,
  input  logic                  reset,
  signed_value_counter_if.slave bus
);

  logic              up_lvl, down_lvl, clr_lvl;
  logic [2:0]        prev_q;
  logic              up_rise, down_rise, clr_rise, both;
  logic              step_up_c, step_dn_c;
  logic signed [7:0] value_q, value_d;
  logic              changed_q, changed_d;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk_100MHz(clk_100MHz), .reset(reset), .btn(bus.btn_up),    .level(up_lvl)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk_100MHz(clk_100MHz), .reset(reset), .btn(bus.btn_down),  .level(down_lvl)
  );
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk_100MHz(clk_100MHz), .reset(reset), .btn(bus.btn_clear), .level(clr_lvl)
  );

  // Previous debounced levels for rising-edge detection.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) prev_q <= 3'b000;
    else       prev_q <= {clr_lvl, down_lvl, up_lvl};
  end

  assign up_rise   = up_lvl   & ~prev_q[0];
  assign down_rise = down_lvl & ~prev_q[1];
  assign clr_rise  = clr_lvl  & ~prev_q[2];
  assign both      = up_lvl & down_lvl;

`ifdef SIGNED_VALUE_COUNTER_AUTO_REPEAT_EN
  signed_value_counter_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_rpt_up (
    .clk_100MHz(clk_100MHz), .reset(reset), .held(up_lvl), .rise(up_rise),
    .inhibit(both), .step_c(step_up_c)
  );
  signed_value_counter_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) u_rpt_down (
    .clk_100MHz(clk_100MHz), .reset(reset), .held(down_lvl), .rise(down_rise),
    .inhibit(both), .step_c(step_dn_c)
  );
`else
  assign step_up_c = up_rise   & ~both;
  assign step_dn_c = down_rise & ~both;
`endif

  // Next value: clear wins, then a single step with saturate or wrap.
  always_comb begin
    value_d   = value_q;
    changed_d = 1'b0;
    if (clr_rise) begin
      value_d   = 8'sd0;
      changed_d = (value_q != 8'sd0);
    end else if (step_up_c) begin
      if (!((value_q == VALUE_MAX) && (WRAP == 0))) begin
        value_d   = value_q + 8'sd1;
        changed_d = 1'b1;
      end
    end else if (step_dn_c) begin
      if (!((value_q == VALUE_MIN) && (WRAP == 0))) begin
        value_d   = value_q - 8'sd1;
        changed_d = 1'b1;
      end
    end
  end

  // Value and change-pulse registers.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      value_q   <= 8'sd0;
      changed_q <= 1'b0;
    end else begin
      value_q   <= value_d;
      changed_q <= changed_d;
    end
  end

  assign bus.value   = value_q;
  assign bus.changed = changed_q;

endmodule
